// File: rtl/deserializer_pkg.sv
// Shared constants, width helpers and the accumulator action encoding for the deserializer.
package deserializer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_SHIFT,
      ACC_LOAD,
      ACC_DROP
   } acc_action_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = 1; v < n; v = v << 1) r++;
      return r;
   endfunction

   // Width of bitCount: must represent 0..WIDTH inclusive.
   function automatic int unsigned cnt_width(input int unsigned w);
      return clog2(w + 1);
   endfunction

   // Width of the accumulator bit index: 0..WIDTH-1.
   function automatic int unsigned idx_width(input int unsigned w);
      return clog2(w);
   endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Output holding register with valid/ready handshake; reports whether it can take a new word.
module deser_out_reg
   import deserializer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CW    = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic [CW-1:0]    count,
   input  logic             readyIn,
   output logic [WIDTH-1:0] dataout,
   output logic [CW-1:0]    bitCount,
   output logic             validOut,
   output logic             loadable
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    count_q, count_d;
   logic             valid_q, valid_d;

   // Empty, or draining this cycle: allows a new word every cycle.
   assign loadable = !valid_q || readyIn;

   always_comb begin
      data_d  = data_q;
      count_d = count_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = data;
         count_d = count;
         valid_d = 1'b1;
      end else if (readyIn) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign dataout  = data_q;
   assign bitCount = count_q;
   assign validOut = valid_q;

endmodule

// File: rtl/deserializer_param.sv
// Serial-to-parallel converter: accumulates WIDTH bits (or a flushed partial word) into a handshaked output register.
module deserializer_param
   import deserializer_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b0,
   localparam int unsigned CW       = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             datain,
   input  logic             validIn,
   input  logic             flush,
   input  logic             readyIn,
   output logic [WIDTH-1:0] dataout,
   output logic [CW-1:0]    bitCount,
   output logic             validOut,
   output logic             overflow
);

   localparam int unsigned IW = idx_width(WIDTH);

   logic [WIDTH-1:0] acc_q, acc_d, word;
   logic [IW-1:0]    cnt_q, cnt_d, pos;
   logic [CW-1:0]    count;
   logic             ovf_q, ovf_d;
   logic             full, emit, loadable, load;
   acc_action_e      action;

   // Bits land directly at their final position, so a flushed partial word is already aligned and zero-padded.
   always_comb begin
      pos   = MSB_FIRST ? IW'(WIDTH - 1) - cnt_q : cnt_q;
      word  = acc_q;
      if (validIn) word[pos] = datain;
      count = CW'(cnt_q) + CW'(validIn);
      full  = validIn && (cnt_q == IW'(WIDTH - 1));
      emit  = full || (flush && (validIn || (cnt_q != '0)));
      if (emit)         action = loadable ? ACC_LOAD : ACC_DROP;
      else if (validIn) action = ACC_SHIFT;
      else              action = ACC_IDLE;
   end

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      ovf_d = 1'b0;
      unique case (action)
         ACC_SHIFT: begin
            acc_d = word;
            cnt_d = cnt_q + IW'(1);
         end
         ACC_LOAD: begin
            acc_d = '0;
            cnt_d = '0;
         end
         ACC_DROP: ovf_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign load     = (action == ACC_LOAD);
   assign overflow = ovf_q;

   deser_out_reg #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_out_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .data     (word),
      .count    (count),
      .readyIn  (readyIn),
      .dataout  (dataout),
      .bitCount (bitCount),
      .validOut (validOut),
      .loadable (loadable)
   );

endmodule

// File: tb/tb_deserializer_param.sv
// Directed bench: MSB-first and LSB-first WIDTH=8 instances driven by the same serial stream.
module tb_deserializer_param;

   logic       clk, rst_n, datain, validIn, flush, readyIn;
   logic [7:0] dout_m, dout_l;
   logic [3:0] cnt_m, cnt_l;
   logic       vld_m, vld_l, ovf_m, ovf_l;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   deserializer_param #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst_n(rst_n), .datain(datain), .validIn(validIn), .flush(flush),
      .readyIn(readyIn), .dataout(dout_m), .bitCount(cnt_m), .validOut(vld_m), .overflow(ovf_m)
   );

   deserializer_param #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst_n(rst_n), .datain(datain), .validIn(validIn), .flush(flush),
      .readyIn(readyIn), .dataout(dout_l), .bitCount(cnt_l), .validOut(vld_l), .overflow(ovf_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [7:0] exp_m, input logic [7:0] exp_l,
                             input logic [3:0] exp_cnt);
      check_vec({tag, ".vld_m"},  64'(vld_m),  64'd1);
      check_vec({tag, ".dout_m"}, 64'(dout_m), 64'(exp_m));
      check_vec({tag, ".cnt_m"},  64'(cnt_m),  64'(exp_cnt));
      check_vec({tag, ".vld_l"},  64'(vld_l),  64'd1);
      check_vec({tag, ".dout_l"}, 64'(dout_l), 64'(exp_l));
      check_vec({tag, ".cnt_l"},  64'(cnt_l),  64'(exp_cnt));
   endtask

   task automatic check_idle(input string tag);
      check_vec({tag, ".vld_m"}, 64'(vld_m), 64'd0);
      check_vec({tag, ".vld_l"}, 64'(vld_l), 64'd0);
   endtask

   task automatic check_ovf(input string tag, input logic exp);
      check_vec({tag, ".ovf_m"}, 64'(ovf_m), 64'(exp));
      check_vec({tag, ".ovf_l"}, 64'(ovf_l), 64'(exp));
   endtask

   task automatic check_zero(input string tag);
      check_vec({tag, ".m"}, {49'd0, vld_m, ovf_m, cnt_m, dout_m}, 64'd0);
      check_vec({tag, ".l"}, {49'd0, vld_l, ovf_l, cnt_l, dout_l}, 64'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      datain  = b;
      validIn = 1'b1;
      tick();
      validIn = 1'b0;
      datain  = 1'b0;
   endtask

   logic [7:0]  pat;
   logic [15:0] v;

   initial begin
      rst_n = 1'b0; datain = 1'b0; validIn = 1'b0; flush = 1'b0; readyIn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      tick();

      // Single word, consumer ready: one-cycle validOut right after the 8th bit.
      readyIn = 1'b1;
      pat = 8'hB2;
      for (int i = 0; i < 8; i++) begin
         send_bit(pat[7 - i]);
         if (i == 6) check_idle("w1_pre");
      end
      check_word("w1", 8'hB2, 8'h4D, 4'd8);
      check_ovf("w1", 1'b0);
      tick();
      check_idle("w1_post");

      // 16 consecutive bits: two words.
      v = 16'h174D;
      for (int i = 0; i < 16; i++) begin
         send_bit(v[i]);
         if (i == 7)  check_word("b2b_a", 8'hB2, 8'h4D, 4'd8);
         if (i == 8)  check_idle("b2b_gap");
         if (i == 15) check_word("b2b_b", 8'hE8, 8'h17, 4'd8);
      end
      tick();
      check_idle("b2b_post");

      // Backpressure: first word held, 16th bit dropped with overflow.
      readyIn = 1'b0;
      for (int i = 0; i < 16; i++) begin
         send_bit(v[i]);
         if (i == 7)  check_word("bp_first", 8'hB2, 8'h4D, 4'd8);
         if (i == 14) begin
            check_word("bp_hold", 8'hB2, 8'h4D, 4'd8);
            check_ovf("bp_pre", 1'b0);
         end
      end
      check_ovf("bp_drop", 1'b1);
      check_word("bp_stable", 8'hB2, 8'h4D, 4'd8);
      tick();
      check_ovf("bp_pulse", 1'b0);
      readyIn = 1'b1;
      send_bit(1'b1);
      check_word("bp_second", 8'hE9, 8'h97, 4'd8);
      check_ovf("bp_second", 1'b0);
      tick();
      check_idle("bp_post");

      // Flush of a partial word.
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      check_idle("fl_pre");
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_word("fl3", 8'hC0, 8'h03, 4'd3);
      tick();
      check_idle("fl3_post");
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_idle("fl_empty");
      check_ovf("fl_empty", 1'b0);

      // Flush together with a bit in the same cycle.
      send_bit(1'b1); send_bit(1'b0);
      datain = 1'b1; validIn = 1'b1; flush = 1'b1;
      tick();
      validIn = 1'b0; flush = 1'b0; datain = 1'b0;
      check_word("fl_same", 8'hA0, 8'h05, 4'd3);
      tick();

      // Flush on the last bit behaves as a full word.
      for (int i = 0; i < 7; i++) send_bit(v[i]);
      datain = v[7]; validIn = 1'b1; flush = 1'b1;
      tick();
      validIn = 1'b0; flush = 1'b0; datain = 1'b0;
      check_word("fl_full", 8'hB2, 8'h4D, 4'd8);
      tick();
      check_idle("fl_full_post");

      // Asynchronous reset mid-word with a held word present.
      readyIn = 1'b0;
      for (int i = 0; i < 8; i++) send_bit(v[i]);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      check_word("rst_pre", 8'hB2, 8'h4D, 4'd8);
      #3 rst_n = 1'b0;
      #1 check_zero("rst_async");
      #2 rst_n = 1'b1;
      readyIn = 1'b1;
      for (int i = 0; i < 8; i++) send_bit(pat[7 - i]);
      check_word("rst_after", 8'hB2, 8'h4D, 4'd8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/deserializer_param.md
DESERIALIZER_PARAM -- requirements
Module: deserializer_param

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32: number of serial bits per output word, legal range 2..64.
REQ-002 The module SHALL have parameter MSB_FIRST, default 0: 0 places the first received bit at dataout[0], 1 places it at dataout[WIDTH-1].
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port datain, input, 1 bit: serial data bit, sampled when validIn=1.
REQ-006 The module SHALL have port validIn, input, 1 bit: datain is valid this cycle.
REQ-007 The module SHALL have port flush, input, 1 bit: emit the pending partial word.
REQ-008 The module SHALL have port dataout, output, WIDTH bits: assembled word.
REQ-009 The module SHALL have port bitCount, output, CW=clog2(WIDTH+1) bits: number of valid bits in dataout.
REQ-010 The module SHALL have port validOut, output, 1 bit: dataout/bitCount hold a word.
REQ-011 The module SHALL have port readyIn, input, 1 bit: consumer accepts the word; transfer occurs when validOut=1 and readyIn=1.
REQ-012 The module SHALL have port overflow, output, 1 bit: one-cycle pulse, a serial bit was dropped.

Function
REQ-013 Two stages SHALL exist: an accumulator (shift register plus bit counter cnt, range 0..WIDTH-1) and one output holding register.
REQ-014 A bit SHALL be accepted into the accumulator at each rising edge with validIn=1, incrementing cnt, unless REQ-018 applies.
REQ-015 A word SHALL be complete when a bit is accepted with cnt=WIDTH-1; the word is loaded into the holding register on that edge, cnt returns to 0, and validOut=1 with bitCount=WIDTH from the next cycle (latency 1 cycle after the last bit).
REQ-016 The holding register SHALL be loadable when it is empty or when it is transferring in the same cycle (validOut=1 and readyIn=1); back-to-back words therefore run at full rate with no bubble.
REQ-017 validOut, dataout and bitCount SHALL remain stable while validOut=1 and readyIn=0.
REQ-018 If a word completes or a flush is requested while the holding register is not loadable, the completing bit SHALL be dropped, cnt SHALL stay at WIDTH-1, overflow SHALL pulse for 1 cycle, and a pending flush SHALL be retried while flush remains high.
REQ-019 flush=1 with cnt>0 SHALL load the partial word (including any bit accepted in the same cycle) with bitCount = bits held, unused positions zero (MSB_FIRST=1: left-aligned from dataout[WIDTH-1]; 0: right-aligned from dataout[0]), and clear cnt.
REQ-020 flush=1 with cnt=0 and validIn=0 SHALL be a no-op; flush with cnt=WIDTH-1 and validIn=1 SHALL behave as a normal full word.
REQ-021 overflow SHALL NOT assert in any case other than REQ-018.

Reset
REQ-022 rst_n=0 SHALL immediately clear cnt, the accumulator, dataout, bitCount, validOut and overflow to 0, including mid-word (partial bits discarded).
REQ-023 The first bit accepted after rst_n deasserts SHALL be bit 0 of a new word.

Structure
REQ-024 Package deserializer_pkg SHALL hold the clog2 function, the CW width derivation, and the default WIDTH constant (32).
REQ-025 Holding register plus handshake SHALL be sub-module deser_out_reg (load, data, count in; dataout, bitCount, validOut out; readyIn in; loadable out).

Verification (WIDTH=8)
REQ-026 MSB_FIRST=1, readyIn=1, bits 1,0,1,1,0,0,1,0 -> dataout=8'hB2, bitCount=8, validOut=1 for exactly one cycle, on the cycle after the 8th bit.
REQ-027 MSB_FIRST=0, same bits -> dataout=8'h4D; 16 consecutive bits -> two words on consecutive validOut cycles.
REQ-028 readyIn=0, 16 bits sent -> first word held stable, 16th bit dropped, overflow pulses once, cnt=7; then readyIn=1 and one more bit -> second word delivered with that bit in the last position.
REQ-029 MSB_FIRST=1, bits 1,1,0 then flush -> dataout=8'hC0, bitCount=3; MSB_FIRST=0 -> dataout=8'h03; flush with cnt=0 -> no validOut.
REQ-030 5 bits sent, rst_n pulsed low mid-cycle -> all outputs 0 at once; next 8 bits 1,0,1,1,0,0,1,0 (MSB_FIRST=1) -> dataout=8'hB2.
